// File: rtl/cordic_z_sequencer.sv
// Iterative CORDIC angle-path (Z) engine: iteration counter, arctangent ROM and
// Z accumulator, serving both rotation and vectoring modes.
module cordic_z_sequencer #(
    parameter int unsigned ITER = 16
) (
    input  logic        C,
    input  logic        R_n,
    input  logic        CE,
    input  logic        START,
    input  logic        MODE,
    input  logic [31:0] Z0,
    input  logic        DIR_IN,
    output logic        DIR_OUT,
    output logic [4:0]  ITER_IDX,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] ZOUT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_z;
    logic [4:0]  r_idx;
    logic        r_mode;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_atan;
    logic        w_add;
    logic        w_last;

    // atan(2^-i) in binary-angle units (full turn = 2^32), rounded to nearest
    always_comb begin
        w_atan = '0;
        case (r_idx)
            5'd0:  w_atan = 32'h2000_0000;
            5'd1:  w_atan = 32'h12E4_051E;
            5'd2:  w_atan = 32'h09FB_385B;
            5'd3:  w_atan = 32'h0511_11D4;
            5'd4:  w_atan = 32'h028B_0D43;
            5'd5:  w_atan = 32'h0145_D7E1;
            5'd6:  w_atan = 32'h00A2_F61E;
            5'd7:  w_atan = 32'h0051_7C55;
            5'd8:  w_atan = 32'h0028_BE53;
            5'd9:  w_atan = 32'h0014_5F2F;
            5'd10: w_atan = 32'h000A_2F98;
            5'd11: w_atan = 32'h0005_17CC;
            5'd12: w_atan = 32'h0002_8BE6;
            5'd13: w_atan = 32'h0001_45F3;
            5'd14: w_atan = 32'h0000_A2FA;
            5'd15: w_atan = 32'h0000_517D;
            5'd16: w_atan = 32'h0000_28BE;
            5'd17: w_atan = 32'h0000_145F;
            5'd18: w_atan = 32'h0000_0A30;
            5'd19: w_atan = 32'h0000_0518;
            5'd20: w_atan = 32'h0000_028C;
            5'd21: w_atan = 32'h0000_0146;
            5'd22: w_atan = 32'h0000_00A3;
            5'd23: w_atan = 32'h0000_0051;
            5'd24: w_atan = 32'h0000_0029;
            5'd25: w_atan = 32'h0000_0014;
            5'd26: w_atan = 32'h0000_000A;
            5'd27: w_atan = 32'h0000_0005;
            5'd28: w_atan = 32'h0000_0003;
            5'd29: w_atan = 32'h0000_0001;
            5'd30: w_atan = 32'h0000_0001;
            default: w_atan = '0;
        endcase
    end

    // Rotation drives Z toward zero from its sign; vectoring follows the X/Y path
    assign w_add  = r_mode ? DIR_IN : r_z[31];
    assign w_last = (r_idx == 5'(ITER - 1));

    always_ff @(posedge C) begin
        if (!R_n) begin
            r_state <= S_IDLE;
            r_z     <= '0;
            r_idx   <= '0;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (CE) begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_z     <= Z0;
                        r_mode  <= MODE;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_z <= w_add ? (r_z + w_atan) : (r_z - w_atan);
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by BUSY so the direction reads 0 outside an operation
    assign DIR_OUT  = r_busy & ~r_z[31];
    assign ITER_IDX = r_idx;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign ZOUT     = r_z;

endmodule
